// File: rtl/gyro_pkg.sv
// Shared constants for the gyro square-wave demodulator: state encoding,
// default datapath widths and output saturation limits.
package gyro_pkg;

   // Demodulator states
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WAIT_H = 3'd1;
   localparam logic [2:0] ST_ACC_H  = 3'd2;
   localparam logic [2:0] ST_WAIT_L = 3'd3;
   localparam logic [2:0] ST_ACC_L  = 3'd4;

   // Default widths
   localparam int ADC_W  = 14;
   localparam int ACC_W  = 48;
   localparam int MEAS_W = 10;

   // Signed output range for the default measurement width
   localparam int SAT_MAX = (1 << (MEAS_W - 1)) - 1;
   localparam int SAT_MIN = -(1 << (MEAS_W - 1));

endpackage

// File: rtl/gyro_demod_meas_if.sv
// Sample/configuration/measurement bundle between the ADC front end and the
// demodulator. The master side supplies samples and settings.
interface gyro_demod_meas_if #(
   parameter int ADC_W  = gyro_pkg::ADC_W,
   parameter int MEAS_W = gyro_pkg::MEAS_W
);
   logic signed [ADC_W-1:0]  i_adc;
   logic        [31:0]       i_freq_cnt;
   logic        [31:0]       i_wait_cnt;
   logic        [4:0]        i_shift;
   logic                     o_mod;
   logic signed [MEAS_W-1:0] o_meas;
   logic                     o_meas_valid;

   modport master (
      output i_adc, i_freq_cnt, i_wait_cnt, i_shift,
      input  o_mod, o_meas, o_meas_valid
   );

   modport slave (
      input  i_adc, i_freq_cnt, i_wait_cnt, i_shift,
      output o_mod, o_meas, o_meas_valid
   );
endinterface

// File: rtl/gyro_meas_sat.sv
// Registered arithmetic right shift and saturation of the period difference
// down to the measurement width. One clock of latency.
module gyro_meas_sat #(
   parameter int ACC_W  = gyro_pkg::ACC_W,
   parameter int MEAS_W = gyro_pkg::MEAS_W
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic signed [ACC_W-1:0]  i_diff,
   input  logic        [4:0]        i_shift,
   input  logic                     i_valid,
   output logic signed [MEAS_W-1:0] o_meas,
   output logic                     o_meas_valid
);
   localparam logic signed [MEAS_W-1:0] MEAS_MAX = {1'b0, {(MEAS_W-1){1'b1}}};
   localparam logic signed [MEAS_W-1:0] MEAS_MIN = {1'b1, {(MEAS_W-1){1'b0}}};

   logic signed [ACC_W-1:0]  scaled;
   logic signed [MEAS_W-1:0] sat_d;

   // Shift, then clip whenever the bits above the output sign disagree with it
   always_comb begin
      scaled = i_diff >>> i_shift;
      if (!scaled[ACC_W-1] && (|scaled[ACC_W-2:MEAS_W-1])) begin
         sat_d = MEAS_MAX;
      end else if (scaled[ACC_W-1] && !(&scaled[ACC_W-2:MEAS_W-1])) begin
         sat_d = MEAS_MIN;
      end else begin
         sat_d = scaled[MEAS_W-1:0];
      end
   end

   // Output register; measurement holds between strobes
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_meas       <= '0;
         o_meas_valid <= 1'b0;
      end else begin
         o_meas_valid <= i_valid;
         if (i_valid) o_meas <= sat_d;
      end
   end
endmodule

// File: rtl/gyro_demod_meas.sv
// Square-wave bias modulator and synchronous demodulator. Integrates the
// settled part of each half period and emits one saturated difference per
// period of exactly 2N clocks.
module gyro_demod_meas
   import gyro_pkg::*;
#(
   parameter int ADC_W  = gyro_pkg::ADC_W,
   parameter int ACC_W  = gyro_pkg::ACC_W,
   parameter int MEAS_W = gyro_pkg::MEAS_W
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   gyro_demod_meas_if.slave bus
);
   logic [2:0]              state_q, state_d;
   logic [31:0]             cnt_q, cnt_d;
   logic [31:0]             n_q, w_q;
   logic [4:0]              shift_q;
   logic signed [ACC_W-1:0] acc_q, acc_d, sum_h_q, sum_h_d, diff_q, diff_d;
   logic                    diff_vld_q, diff_vld_d;
   logic                    mod_q;
   logic [31:0]             n_in, n_eff, w_eff;
   logic                    first_h, in_acc, last;
   logic signed [ACC_W-1:0] adc_ext;

   // Effective period settings: at cnt=0 of the high half the fresh inputs apply
   always_comb begin
      n_in    = (bus.i_freq_cnt < 32'd2) ? 32'd2 : bus.i_freq_cnt;
      first_h = ((state_q == ST_WAIT_H) || (state_q == ST_ACC_H)) && (cnt_q == 32'd0);
      n_eff   = first_h ? n_in : n_q;
      w_eff   = first_h ? bus.i_wait_cnt : w_q;
      in_acc  = (state_q == ST_ACC_H) || (state_q == ST_ACC_L);
      last    = (state_q != ST_IDLE) && (cnt_q == n_eff - 32'd1);
      adc_ext = {{(ACC_W-ADC_W){bus.i_adc[ADC_W-1]}}, bus.i_adc};
      acc_d   = ((cnt_q == 32'd0) ? '0 : acc_q) + (in_acc ? adc_ext : '0);
   end

   // Next-state, half-boundary and difference logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sum_h_d    = sum_h_q;
      diff_d     = diff_q;
      diff_vld_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d   = 32'd0;
            state_d = (bus.i_wait_cnt == 32'd0) ? ST_ACC_H : ST_WAIT_H;
         end
         ST_WAIT_H, ST_ACC_H: begin
            if (last) begin
               sum_h_d = acc_d;
               cnt_d   = 32'd0;
               state_d = (w_eff == 32'd0) ? ST_ACC_L : ST_WAIT_L;
            end else begin
               cnt_d   = cnt_q + 32'd1;
               state_d = (cnt_q + 32'd1 >= w_eff) ? ST_ACC_H : ST_WAIT_H;
            end
         end
         ST_WAIT_L, ST_ACC_L: begin
            if (last) begin
               diff_d     = sum_h_q - acc_d;
               diff_vld_d = 1'b1;
               cnt_d      = 32'd0;
               // Next period's W is the one about to be latched
               state_d    = (bus.i_wait_cnt == 32'd0) ? ST_ACC_H : ST_WAIT_H;
            end else begin
               cnt_d   = cnt_q + 32'd1;
               state_d = (cnt_q + 32'd1 >= w_eff) ? ST_ACC_L : ST_WAIT_L;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 32'd0;
         end
      endcase
   end

   // State, counters, sums and per-period parameter latch
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         sum_h_q    <= '0;
         diff_q     <= '0;
         diff_vld_q <= 1'b0;
         mod_q      <= 1'b0;
         n_q        <= 32'd2;
         w_q        <= '0;
         shift_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         sum_h_q    <= sum_h_d;
         diff_q     <= diff_d;
         diff_vld_q <= diff_vld_d;
         mod_q      <= (state_d == ST_WAIT_H) || (state_d == ST_ACC_H);
         if (first_h) begin
            n_q     <= n_in;
            w_q     <= bus.i_wait_cnt;
            shift_q <= bus.i_shift;
         end
      end
   end

   logic signed [MEAS_W-1:0] meas;
   logic                     meas_valid;

   // shift_q still holds the finished period's value when the diff is scaled
   gyro_meas_sat #(
      .ACC_W  (ACC_W),
      .MEAS_W (MEAS_W)
   ) u_sat (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_diff       (diff_q),
      .i_shift      (shift_q),
      .i_valid      (diff_vld_q),
      .o_meas       (meas),
      .o_meas_valid (meas_valid)
   );

   assign bus.o_mod        = mod_q;
   assign bus.o_meas       = meas;
   assign bus.o_meas_valid = meas_valid;
endmodule
